// File: rtl/poly_eval_ctrl.sv
// poly_eval_ctrl: evaluates y = (a*x + b)*x + c over four micro-steps using a
// single shared multiplier and a single shared adder.
// Optional build macro POLY_EVAL_SAT_EN: clamp every step to the signed CW range
// and expose a sticky 'sat' flag for the evaluation.
//
// state | meaning
// IDLE  | ready; latch operands when inicio is high
// MUL1  | acc <= a_r * x_r
// ADD1  | acc <= acc + b_r
// MUL2  | acc <= acc * x_r
// ADD2  | y   <= acc + c_r
// DONE  | valid pulse, back to IDLE
module poly_eval_ctrl #(
  parameter int XW = 8,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inicio,
  input  logic signed [XW-1:0] x,
  input  logic signed [CW-1:0] a,
  input  logic signed [CW-1:0] b,
  input  logic signed [CW-1:0] c,
  output logic signed [CW-1:0] y,
  output logic                 ready,
`ifdef POLY_EVAL_SAT_EN
  output logic                 sat,
`endif
  output logic                 valid
);

  typedef enum logic [2:0] {IDLE, MUL1, ADD1, MUL2, ADD2, DONE} state_t;

  state_t state_q, state_d;
  logic signed [CW-1:0] x_q, x_d, a_q, a_d, b_q, b_d, c_q, c_d;
  logic signed [CW-1:0] acc_q, acc_d, y_q, y_d;
  logic signed [CW-1:0] mul_a, add_b, mul_res, add_res;

  // shared operand muxes: multiplier takes a_r or acc, adder takes b_r or c_r
  assign mul_a = (state_q == MUL1) ? a_q : acc_q;
  assign add_b = (state_q == ADD1) ? b_q : c_q;

`ifdef POLY_EVAL_SAT_EN
  logic                   sat_q, sat_d, sat_run_q, sat_run_d;
  logic signed [2*CW-1:0] mul_a_ext, x_ext, prod;
  logic signed [CW:0]     sum_full;
  logic                   mul_ovf, add_ovf;

  assign mul_a_ext = {{CW{mul_a[CW-1]}}, mul_a};
  assign x_ext     = {{CW{x_q[CW-1]}}, x_q};
  assign prod      = mul_a_ext * x_ext;
  assign sum_full  = {acc_q[CW-1], acc_q} + {add_b[CW-1], add_b};

  // overflow when the bits above the result sign are not a pure sign extension
  assign mul_ovf = !((&prod[2*CW-1:CW-1]) || !(|prod[2*CW-1:CW-1]));
  assign add_ovf = sum_full[CW] != sum_full[CW-1];

  // clamp toward the sign of the true result
  always_comb begin
    mul_res = prod[CW-1:0];
    add_res = sum_full[CW-1:0];
    if (mul_ovf) mul_res = prod[2*CW-1] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
    if (add_ovf) add_res = sum_full[CW] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
  end

  assign sat = sat_q;
`else
  // wrap-around: low CW bits of the product and sum are exactly the modulo result
  assign mul_res = mul_a * x_q;
  assign add_res = acc_q + add_b;
`endif

  assign ready = (state_q == IDLE);
  assign valid = (state_q == DONE);
  assign y     = y_q;

  // next-state and datapath update
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    y_d     = y_q;
`ifdef POLY_EVAL_SAT_EN
    sat_d     = sat_q;
    sat_run_d = sat_run_q;
`endif
    case (state_q)
      IDLE: begin
        if (inicio) begin
          x_d     = {{(CW-XW){x[XW-1]}}, x};
          a_d     = a;
          b_d     = b;
          c_d     = c;
          state_d = MUL1;
`ifdef POLY_EVAL_SAT_EN
          sat_d     = 1'b0;
          sat_run_d = 1'b0;
`endif
        end
      end
      MUL1, MUL2: begin
        acc_d   = mul_res;
        state_d = (state_q == MUL1) ? ADD1 : ADD2;
`ifdef POLY_EVAL_SAT_EN
        sat_run_d = sat_run_q | mul_ovf;
`endif
      end
      ADD1: begin
        acc_d   = add_res;
        state_d = MUL2;
`ifdef POLY_EVAL_SAT_EN
        sat_run_d = sat_run_q | add_ovf;
`endif
      end
      ADD2: begin
        y_d     = add_res;
        state_d = DONE;
`ifdef POLY_EVAL_SAT_EN
        sat_d = sat_run_q | add_ovf;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
`ifdef POLY_EVAL_SAT_EN
      sat_q     <= 1'b0;
      sat_run_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
`ifdef POLY_EVAL_SAT_EN
      sat_q     <= sat_d;
      sat_run_q <= sat_run_d;
`endif
    end
  end

endmodule

// File: tb/tb_poly_eval_ctrl.sv
// Directed bench for poly_eval_ctrl; expectations are hand-computed Horner results.
module tb_poly_eval_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               inicio = 1'b0;
  logic signed [7:0]  x = '0;
  logic signed [15:0] a = '0, b = '0, c = '0;
  logic signed [15:0] y;
  logic               ready, valid;
`ifdef POLY_EVAL_SAT_EN
  logic               sat;
`endif

  int checks = 0;
  int failures = 0;

  poly_eval_ctrl #(.XW(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .inicio(inicio),
    .x(x), .a(a), .b(b), .c(c),
    .y(y), .ready(ready),
`ifdef POLY_EVAL_SAT_EN
    .sat(sat),
`endif
    .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (y !== 16'sd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", y); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    rst = 1'b0;
    step();
  endtask

  // inicio held high: result every 6 cycles, ready low for cycles 1..5
  task automatic test_held_start();
    logic signed [15:0] exp_y;
    x = 8'sd1; a = 16'sd2; b = 16'sd3; c = 16'sd4;
    inicio = 1'b1;
    exp_y = 16'sd0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 12) inicio = 1'b0;
      if (i % 6 == 5) exp_y = 16'sd9;
      checks++;
      if (ready !== (i % 6 == 0)) begin failures++; $display("FAIL held_ready cyc=%0d got=%b exp=%b", i, ready, (i % 6 == 0)); end
      checks++;
      if (valid !== (i % 6 == 5)) begin failures++; $display("FAIL held_valid cyc=%0d got=%b exp=%b", i, valid, (i % 6 == 5)); end
      checks++;
      if (y !== exp_y) begin failures++; $display("FAIL held_y cyc=%0d got=%0d exp=%0d", i, y, exp_y); end
    end
    step();
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s_wait_ready got=%b exp=1", name, ready);
    end
  endtask

  // one single-cycle start; valid exactly on cycle 5 with the expected y
  task automatic run_eval(input string name, input logic signed [7:0] xv,
                          input logic signed [15:0] av, input logic signed [15:0] bv,
                          input logic signed [15:0] cv, input logic signed [15:0] exp_y);
    wait_ready(name);
    x = xv; a = av; b = bv; c = cv;
    inicio = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      inicio = 1'b0;
      checks++;
      if (valid !== (i == 5)) begin failures++; $display("FAIL %s_valid cyc=%0d got=%b exp=%b", name, i, valid, (i == 5)); end
      if (i >= 5) begin
        checks++;
        if (y !== exp_y) begin failures++; $display("FAIL %s_y cyc=%0d got=%0d exp=%0d", name, i, y, exp_y); end
      end
    end
  endtask

  task automatic test_intermediate();
    logic signed [15:0] exp_acc [3];
    exp_acc[0] = -16'sd6; exp_acc[1] = -16'sd11; exp_acc[2] = 16'sd33;
    wait_ready("inter");
    x = -8'sd3; a = 16'sd2; b = -16'sd5; c = 16'sd7;
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut.acc_q !== exp_acc[i]) begin failures++; $display("FAIL inter_acc%0d got=%0d exp=%0d", i, dut.acc_q, exp_acc[i]); end
    end
    step();
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL inter_valid got=%b exp=1", valid); end
    checks++; if (y !== 16'sd40) begin failures++; $display("FAIL inter_y got=%0d exp=40", y); end
`ifdef POLY_EVAL_SAT_EN
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL inter_sat got=%b exp=0", sat); end
`endif
    step();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL inter_single_pulse got=%b exp=0", valid); end
  endtask

  task automatic test_overflow();
`ifdef POLY_EVAL_SAT_EN
    run_eval("ovf", 8'sd127, 16'sd4, 16'sd0, 16'sd0, 16'sd32767);
    checks++; if (sat !== 1'b1) begin failures++; $display("FAIL ovf_sat got=%b exp=1", sat); end
`else
    run_eval("ovf", 8'sd127, 16'sd4, 16'sd0, 16'sd0, -16'sd1020);
`endif
  endtask

  // operand changes and an inicio pulse mid-evaluation are ignored
  task automatic test_ignore_busy();
    wait_ready("busy");
    x = 8'sd1; a = 16'sd2; b = 16'sd3; c = 16'sd4;
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    x = 8'sd5; a = 16'sd0; b = 16'sd0; c = 16'sd0;
    step();
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    for (int i = 4; i <= 8; i++) begin
      checks++;
      if (ready !== (i >= 7)) begin failures++; $display("FAIL busy_ready cyc=%0d got=%b exp=%b", i - 1, ready, (i >= 7)); end
      step();
      if (i == 5) begin
        checks++;
        if (valid !== 1'b1 || y !== 16'sd9) begin failures++; $display("FAIL busy_result valid=%b y=%0d exp valid=1 y=9", valid, y); end
      end
    end
    checks++; if (valid !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL busy_no_restart valid=%b ready=%b exp 0/1", valid, ready); end
  endtask

  task automatic test_reset_mid();
    run_eval("pre", 8'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd9);
    wait_ready("mid");
    x = 8'sd2; a = 16'sd3; b = 16'sd1; c = 16'sd1;
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (y !== 16'sd0) begin failures++; $display("FAIL mid_rst_y got=%0d exp=0", y); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", valid); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", ready); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (valid !== 1'b0) begin failures++; $display("FAIL mid_no_pulse cyc=%0d got=%b exp=0", i, valid); end
    end
    run_eval("after_rst", 8'sd2, 16'sd3, 16'sd1, 16'sd1, 16'sd15);
  endtask

  initial begin
    test_reset();
    test_held_start();
    test_intermediate();
    test_overflow();
    test_ignore_busy();
    test_reset_mid();
    run_eval("neg", -8'sd128, -16'sd1, 16'sd0, -16'sd1, -16'sd16385);
    run_eval("mixed", -8'sd2, 16'sd5, 16'sd7, -16'sd3, 16'sd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
